// File: rtl/instr_ptr_fetch.sv
// Program counter and fetch-latency tracker feeding the instruction memory address.
// Optional bounds checking (HALT state, sticky ptr_err) is built when INSTR_PTR_BOUNDS_CHECK_EN is defined.
module instr_ptr_fetch #(
    parameter int INSTR_ADDR_WIDTH = 16,
    parameter int MEM_READ_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        instr_ptr_en,
    input  logic [1:0]                  instr_ptr_load_en,
    input  logic [INSTR_ADDR_WIDTH-1:0] jump_addr,
    input  logic                        alu_cond,
    input  logic [INSTR_ADDR_WIDTH-1:0] max_addr,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_ptr,
    output logic                        instr_valid,
    output logic                        ptr_err
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_READ_LATENCY - 1);

`ifdef INSTR_PTR_BOUNDS_CHECK_EN
    typedef enum logic [1:0] {FETCH_WAIT, READY, HALT} state_t;
`else
    typedef enum logic [1:0] {FETCH_WAIT, READY} state_t;
`endif

    state_t                        r_state;
    logic [2:0]                    r_cnt;
    logic [INSTR_ADDR_WIDTH-1:0]   r_ptr;
    logic                          r_valid;
    logic [INSTR_ADDR_WIDTH-1:0]   w_ptr_inc;
    logic [INSTR_ADDR_WIDTH-1:0]   w_next;

    assign w_ptr_inc = r_ptr + 1'b1;

    // Modes 0 and 3 both increment; mode 2 jumps only when the ALU condition holds.
    always_comb begin
        w_next = w_ptr_inc;
        case (instr_ptr_load_en)
            2'd1:    w_next = jump_addr;
            2'd2:    if (alu_cond) w_next = jump_addr;
            default: w_next = w_ptr_inc;
        endcase
    end

`ifdef INSTR_PTR_BOUNDS_CHECK_EN
    logic r_err;
    assign ptr_err = r_err;
`else
    logic w_unused_max;
    assign w_unused_max = ^max_addr;
    assign ptr_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= FETCH_WAIT;
            r_cnt   <= LAT_M1;
            r_ptr   <= '0;
            r_valid <= 1'b0;
`ifdef INSTR_PTR_BOUNDS_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                READY: begin
                    if (instr_ptr_en) begin
`ifdef INSTR_PTR_BOUNDS_CHECK_EN
                        if (w_next > max_addr) begin
                            r_err   <= 1'b1;
                            r_state <= HALT;
                            r_valid <= 1'b0;
                        end else begin
                            r_ptr   <= w_next;
                            r_state <= FETCH_WAIT;
                            r_cnt   <= LAT_M1;
                            r_valid <= 1'b0;
                        end
`else
                        r_ptr   <= w_next;
                        r_state <= FETCH_WAIT;
                        r_cnt   <= LAT_M1;
                        r_valid <= 1'b0;
`endif
                    end
                end
                FETCH_WAIT: begin
                    // Strobes are dropped here; the control FSM waits for instr_valid.
                    if (r_cnt == 3'd0) begin
                        r_state <= READY;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
`ifdef INSTR_PTR_BOUNDS_CHECK_EN
                HALT: begin
                    r_valid <= 1'b0;
                end
`endif
                default: begin
                    r_state <= FETCH_WAIT;
                    r_cnt   <= LAT_M1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ptr   = r_ptr;
    assign instr_valid = r_valid;

endmodule

// File: doc/instr_ptr_fetch.md
# instr_ptr_fetch

Program-counter and fetch-timing stage that sits directly downstream of the processor control FSM. It consumes the control FSM's `instr_ptr_en` / `instr_ptr_load_en` strobes and the ALU condition bit, and drives the instruction-memory read address. It tracks the memory's fixed read latency and tells the core when the instruction word at the memory output corresponds to the current pointer.

## Interface
Parameters:
- `INSTR_ADDR_WIDTH`, default 16: width of the pointer and jump target.
- `MEM_READ_LATENCY`, default 2: cycles from an address change to valid memory data. Legal range is 1..7.

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `instr_ptr_en`  in  1  pointer update strobe from the control FSM.
- `instr_ptr_load_en`  in  2  update mode: 0 = FALSE (increment), 1 = TRUE (load `jump_addr`), 2 = ALU (conditional), 3 = reserved.
- `jump_addr`  in  INSTR_ADDR_WIDTH  jump target field of the current instruction.
- `alu_cond`  in  1  bit 0 of the ALU result; used only in mode 2.
- `max_addr`  in  INSTR_ADDR_WIDTH  last legal program address. Used only with `INSTR_PTR_BOUNDS_CHECK_EN`.
- `instr_ptr`  out  INSTR_ADDR_WIDTH  instruction-memory read address.
- `instr_valid`  out  1  high when the memory output matches `instr_ptr`.
- `ptr_err`  out  1  sticky out-of-range flag. Tied to 0 when the bounds-check macro is not defined.

## Operation
- The FSM has three states:
  - FETCH_WAIT: waiting out the memory latency.
  - READY: the instruction is valid.
  - HALT: only present with the bounds-check macro.
- Next-pointer computation:
  - Mode 0 or 3: `instr_ptr+1`.
  - Mode 1: `jump_addr`.
  - Mode 2: `alu_cond ? jump_addr : instr_ptr+1`.
- Increment is modulo 2^INSTR_ADDR_WIDTH: `{W{1}}` + 1 wraps to 0, with no flag.
- In READY, `instr_ptr_en`=1 updates `instr_ptr` to the next pointer. The state then goes to FETCH_WAIT and the latency counter loads `MEM_READ_LATENCY-1`.
- In FETCH_WAIT:
  - The counter decrements each cycle. At 0 the state goes to READY.
  - `instr_ptr_en` is ignored: no update and no queuing. The control FSM must not strobe while `instr_valid`=0.
- `instr_valid` = (state == READY), registered.
- A repeated jump to the same address still runs the full FETCH_WAIT.

## Timing
- Reset (`reset`=0 at an edge):
  - `instr_ptr`=0, `instr_valid`=0, `ptr_err`=0.
  - State = FETCH_WAIT, counter = `MEM_READ_LATENCY-1`.
- Reset has priority over every other input, including mid-FETCH_WAIT and in HALT.
- After reset is released at edge R, `instr_valid` rises after edge R+MEM_READ_LATENCY-1. For example, with latency 2 it is high in the cycle after R+1.
- Update accepted at edge N:
  - `instr_ptr` holds the new value from N.
  - `instr_valid` is 0 from N.
  - `instr_valid` returns to 1 from edge N+MEM_READ_LATENCY.
- With latency 1, FETCH_WAIT lasts exactly one cycle. The back-to-back update rate is then one instruction every 2 cycles.
- `jump_addr` and `alu_cond` are sampled only at the accepting edge.

## Configuration
- `INSTR_PTR_BOUNDS_CHECK_EN` defined:
  - An accepted update whose next pointer is greater than `max_addr` does not change `instr_ptr`.
  - `ptr_err` is set (sticky) and the state goes to HALT.
  - In HALT, `instr_valid`=0 and all strobes are ignored until reset.
  - Increment wrap to 0 is never an error. A jump to 0 is always legal.
- Macro not defined:
  - `max_addr` is unused and `ptr_err` is constant 0.
  - No HALT state exists; every computed pointer is applied.

## Test plan
- Reset released, latency 2, no strobes -> `instr_ptr`=0; `instr_valid` is 0 for 1 cycle after release, then 1 and stays 1.
- In READY at ptr 5, mode 0 strobe -> ptr=6; `instr_valid` low 2 cycles then high. Mode 1 with `jump_addr`=0x40 -> ptr=0x40.
- Mode 2 at ptr 0x10, `jump_addr`=0x80: with `alu_cond`=1 -> 0x80; with `alu_cond`=0 -> 0x11.
- Strobe held high continuously through FETCH_WAIT -> exactly one update per READY period; ptr 0→1→2 at edges spaced MEM_READ_LATENCY+... apart (every latency+1 cycles). Reset asserted mid-FETCH_WAIT -> ptr=0 and counter reloaded.
- ptr=0xFFFF, W=16, mode 0 -> ptr=0x0000 with `ptr_err`=0.
- Macro on, `max_addr`=0x20, mode 1 with `jump_addr`=0x21 -> ptr unchanged; `ptr_err`=1 and `instr_valid`=0 until reset; further strobes ignored; reset clears both.
